rv32_inst_encoder: RTL and testbench
====================================

Name: rv32_inst_encoder

Overview:
- Pipelined RV32I instruction encoder. It is the inverse of the rv32 field decode: it takes a decoded field bundle (opcode, rd, rs1, rs2, funct3, funct7, funct12, imm) and produces the 32-bit instruction word.
- Derives the instruction format from the opcode.
- Range-checks immediates and flags unencodable inputs.
- Used by the trace-replay/stimulus generator and by the debug-module instruction injector.
- Valid/ready on both sides, 2-stage pipeline.

Parameters:
- TAG_WIDTH, 4, width of the opaque sideband tag carried in order from input to output.
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock; all flops rise on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_opcode  in  7  rv32_opcode_t.
- in_rd, in_rs1, in_rs2  in  5 each  register addresses.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7; R-type and shift-immediate upper bits.
- in_funct12  in  12  SYSTEM immediate field.
- in_imm  in  32  immediate, fully sign-extended, byte offset (decoder convention).
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts.
- out_inst  out  32  rv32_inst_t encoded word; 0 when out_error=1.
- out_error  out  1  bundle was unencodable.
- out_tag  out  TAG_WIDTH  tag of the bundle.
- err_count  out  ERR_CNT_WIDTH  saturating count of error bundles delivered.

Behaviour:
- Reset (async assert, sync release): both stage valids 0, out_valid=0, out_inst=0, out_error=0, out_tag=0, err_count=0. Reset mid-operation drops all in-flight bundles.
- Stage S1 registers the inputs plus a decoded format and error bit. Stage S2 is the output register holding the assembled word.
- Handshake:
  - Transfer occurs when valid && ready.
  - S2 loads when it is empty or out_ready=1.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid || s1_advance; combinational from out_ready, no input-to-output combinational path.
  - out_* are stable while out_valid && !out_ready.
- Latency: 2 cycles from input transfer to out_valid. Throughput is 1/cycle. Capacity is 2 bundles. Order is preserved.
- Format by opcode:
  - 0110111/0010111 U
  - 1101111 J
  - 1100111, 0000011, 0001111 I
  - 0010011 I, except funct3 001/101, which is shift form
  - 1100011 B
  - 0100011 S
  - 0110011 R
  - 1110011 SYS (I-layout with funct12 in [31:20])
  - Any other opcode is an error.
- Shift form encoding: inst[31:25]=funct7, inst[24:20]=imm[4:0].
- Error conditions:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0]≠0.
  - Shift form: imm[31:5]≠0, or funct7 not in {0000000, 0100000}.
  - R: funct7 not in {0000000, 0100000}.
  - Unused fields are ignored, not checked.
- On error: out_inst=0 and out_error=1; the tag still propagates.
- err_count increments on each output transfer with out_error=1 and saturates at all-ones.
- Simultaneous input transfer and output transfer when full: both occur the same cycle, with no bubble.

Test Plan:
- ADDI: opcode=0010011, rd=1, rs1=0, funct3=0, imm=5, tag=3 → out_inst=0x00500093, out_error=0, out_tag=3, 2 cycles after transfer.
- LUI and BEQ: LUI rd=5, imm=0x12345000 → 0x123452B7. BEQ rs1=1, rs2=2, funct3=0, imm=0xFFFFFFFC → 0xFE208EE3.
- Errors: ADDI imm=2048 → out_inst=0, out_error=1, err_count=1. JAL imm=3 → error, err_count=2. Opcode 1111111 → error, err_count=3.
- Backpressure with tags 0..3 offered back-to-back:
  - With out_ready=0, exactly 2 are accepted, then in_ready=0.
  - out_inst/out_tag hold stable at tag 0 for 3 cycles.
  - After release, tags 0,1,2,3 arrive in order, 1 per cycle, none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with both stages full → out_valid=0, err_count=0 immediately (async). After release, in_ready=1 and the next bundle emerges with 2-cycle latency.
- Saturation: with ERR_CNT_WIDTH=2, 5 error bundles → err_count sticks at 3.

Source files
------------

// File: rtl/rv32_inst_encoder.sv
// RV32I instruction encoder: turns a decoded field bundle back into a 32-bit word.
// Two-stage valid/ready pipeline; S1 registers fields plus format/error, S2 holds the assembled word.
module rv32_inst_encoder #(
    parameter int TAG_WIDTH     = 4,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               in_opcode,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic [11:0]              in_funct12,
    input  logic [31:0]              in_imm,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic                     out_error,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_SH  = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6,
        FMT_SYS = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    function automatic logic op_known(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_FENCE,
            OP_IMM, OP_BRANCH, OP_STORE, OP_REG, OP_SYSTEM: op_known = 1'b1;
            default:                                        op_known = 1'b0;
        endcase
    endfunction

    // Unknown opcodes map to FMT_R; they are flagged separately by op_known.
    function automatic fmt_e fmt_of(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_LUI, OP_AUIPC:           fmt_of = FMT_U;
            OP_JAL:                     fmt_of = FMT_J;
            OP_JALR, OP_LOAD, OP_FENCE: fmt_of = FMT_I;
            OP_IMM:                     fmt_of = ((f3 == 3'b001) || (f3 == 3'b101)) ? FMT_SH : FMT_I;
            OP_BRANCH:                  fmt_of = FMT_B;
            OP_STORE:                   fmt_of = FMT_S;
            OP_SYSTEM:                  fmt_of = FMT_SYS;
            default:                    fmt_of = FMT_R;
        endcase
    endfunction

    function automatic logic fields_bad(input fmt_e fmt, input logic [6:0] f7, input logic [31:0] imm);
        logic f7_ok;
        f7_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        case (fmt)
            FMT_I, FMT_S: fields_bad = (imm[31:11] != {21{imm[11]}});
            FMT_B:        fields_bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
            FMT_J:        fields_bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
            FMT_U:        fields_bad = (imm[11:0] != 12'd0);
            FMT_SH:       fields_bad = (imm[31:5] != 27'd0) || !f7_ok;
            FMT_R:        fields_bad = !f7_ok;
            FMT_SYS:      fields_bad = 1'b0;
            default:      fields_bad = 1'b1;
        endcase
    endfunction

    logic                     s1_valid_q;
    logic [6:0]               s1_op_q;
    logic [4:0]               s1_rd_q;
    logic [4:0]               s1_rs1_q;
    logic [4:0]               s1_rs2_q;
    logic [2:0]               s1_f3_q;
    logic [6:0]               s1_f7_q;
    logic [11:0]              s1_f12_q;
    logic [31:0]              s1_imm_q;
    logic [TAG_WIDTH-1:0]     s1_tag_q;
    fmt_e                     s1_fmt_q;
    logic                     s1_err_q;
    fmt_e                     s1_fmt_d;
    logic                     s1_err_d;

    logic                     s2_valid_q;
    logic [31:0]              out_inst_q;
    logic                     out_error_q;
    logic [TAG_WIDTH-1:0]     out_tag_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
    logic [31:0]              word_s;
    logic [31:0]              inst_d;
    logic                     s2_load;

    assign s2_load   = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_load;
    assign out_valid = s2_valid_q;
    assign out_inst  = out_inst_q;
    assign out_error = out_error_q;
    assign out_tag   = out_tag_q;
    assign err_count = err_cnt_q;

    // Classify the incoming bundle so S2 only has to assemble bits.
    always_comb begin
        s1_fmt_d = fmt_of(in_opcode, in_funct3);
        s1_err_d = !op_known(in_opcode) || fields_bad(s1_fmt_d, in_funct7, in_imm);
    end

    // Scatter S1 fields into the instruction layout of the registered format.
    always_comb begin
        word_s = 32'd0;
        case (s1_fmt_q)
            FMT_R:   word_s = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
            FMT_I:   word_s = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
            FMT_SH:  word_s = {s1_f7_q, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
            FMT_S:   word_s = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
            FMT_B:   word_s = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                               s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
            FMT_U:   word_s = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
            FMT_J:   word_s = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                               s1_rd_q, s1_op_q};
            FMT_SYS: word_s = {s1_f12_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
            default: word_s = 32'd0;
        endcase
        if (s1_err_q) begin
            inst_d = 32'd0;
        end else begin
            inst_d = word_s;
        end
    end

    // Stage S1: capture the bundle whenever the slot is free or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 7'd0;
            s1_rd_q    <= 5'd0;
            s1_rs1_q   <= 5'd0;
            s1_rs2_q   <= 5'd0;
            s1_f3_q    <= 3'd0;
            s1_f7_q    <= 7'd0;
            s1_f12_q   <= 12'd0;
            s1_imm_q   <= 32'd0;
            s1_tag_q   <= '0;
            s1_fmt_q   <= FMT_R;
            s1_err_q   <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_op_q  <= in_opcode;
                s1_rd_q  <= in_rd;
                s1_rs1_q <= in_rs1;
                s1_rs2_q <= in_rs2;
                s1_f3_q  <= in_funct3;
                s1_f7_q  <= in_funct7;
                s1_f12_q <= in_funct12;
                s1_imm_q <= in_imm;
                s1_tag_q <= in_tag;
                s1_fmt_q <= s1_fmt_d;
                s1_err_q <= s1_err_d;
            end
        end
    end

    // Stage S2: output register, frozen while the consumer stalls; counts delivered errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            out_inst_q  <= 32'd0;
            out_error_q <= 1'b0;
            out_tag_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_inst_q  <= inst_d;
                    out_error_q <= s1_err_q;
                    out_tag_q   <= s1_tag_q;
                end
            end
            if (s2_valid_q && out_ready && out_error_q && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv32_inst_encoder.sv
// Bench for rv32_inst_encoder: directed cases plus randomized bundles against an arithmetic model.
module tb_rv32_inst_encoder;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] f12;
        logic [31:0] imm;
        logic [3:0]  tag;
    } bundle_t;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready, sat_in_ready;
    logic [6:0]  in_opcode = 7'd0;
    logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [6:0]  in_funct7 = 7'd0;
    logic [11:0] in_funct12 = 12'd0;
    logic [31:0] in_imm = 32'd0;
    logic [3:0]  in_tag = 4'd0;
    logic        out_valid, sat_out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst, sat_out_inst;
    logic        out_error, sat_out_error;
    logic [3:0]  out_tag, sat_out_tag;
    logic [15:0] err_count;
    logic [1:0]  sat_err_count;

    int          n_cmp = 0;
    int          n_mis = 0;
    exp_t        q[$];
    int          model_cnt = 0;
    exp_t        last;
    bit          rnd_bp = 1'b0;

    rv32_inst_encoder #(.TAG_WIDTH(4), .ERR_CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_funct12(in_funct12),
        .in_imm(in_imm), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_error(out_error), .out_tag(out_tag), .err_count(err_count)
    );

    rv32_inst_encoder #(.TAG_WIDTH(4), .ERR_CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_funct12(in_funct12),
        .in_imm(in_imm), .in_tag(in_tag), .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_inst(sat_out_inst), .out_error(sat_out_error), .out_tag(sat_out_tag),
        .err_count(sat_err_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h at %0t", name, obs, exp, $time);
        end
    endtask

    // Reference: legality from signed ranges, layout from the ISA bit map.
    function automatic exp_t model(input bundle_t b);
        exp_t        e;
        int          s;
        logic [31:0] u;
        bit          f7ok, i_bad;
        logic [31:0] i_word;
        s      = $signed(b.imm);
        u      = b.imm;
        f7ok   = (b.f7 == 7'd0) || (b.f7 == 7'd32);
        i_bad  = (s < -2048) || (s > 2047);
        i_word = {u[11:0], b.rs1, b.f3, b.rd, b.op};
        e.tag  = b.tag;
        e.err  = 1'b0;
        e.inst = 32'd0;
        case (b.op)
            7'h37, 7'h17: begin
                e.err  = (u % 32'd4096) != 32'd0;
                e.inst = u + ({27'd0, b.rd} << 7) + {25'd0, b.op};
            end
            7'h6F: begin
                e.err  = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
                e.inst = {u[20], u[10:1], u[11], u[19:12], b.rd, b.op};
            end
            7'h67, 7'h03, 7'h0F: begin
                e.err = i_bad; e.inst = i_word;
            end
            7'h13: begin
                if (b.f3 == 3'd1 || b.f3 == 3'd5) begin
                    e.err  = (u > 32'd31) || !f7ok;
                    e.inst = {b.f7, u[4:0], b.rs1, b.f3, b.rd, b.op};
                end else begin
                    e.err = i_bad; e.inst = i_word;
                end
            end
            7'h63: begin
                e.err  = (s < -4096) || (s > 4095) || (s % 2 != 0);
                e.inst = {u[12], u[10:5], b.rs2, b.rs1, b.f3, u[4:1], u[11], b.op};
            end
            7'h23: begin
                e.err  = i_bad;
                e.inst = {u[11:5], b.rs2, b.rs1, b.f3, u[4:0], b.op};
            end
            7'h33: begin
                e.err  = !f7ok;
                e.inst = {b.f7, b.rs2, b.rs1, b.f3, b.rd, b.op};
            end
            7'h73: e.inst = {b.f12, b.rs1, b.f3, b.rd, b.op};
            default: e.err = 1'b1;
        endcase
        if (e.err) e.inst = 32'd0;
        return e;
    endfunction

    function automatic bundle_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                                   input logic [3:0] tag);
        bundle_t b;
        b = '0;
        b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = f3; b.imm = imm; b.tag = tag;
        return b;
    endfunction

    function automatic bundle_t rand_bundle(input int tag);
        bundle_t    b;
        logic [6:0] ops [0:10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h0F, 7'h13, 7'h63, 7'h23, 7'h33, 7'h73};
        b     = bundle_t'({$urandom, $urandom, $urandom});
        b.op  = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
        b.f7  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 0) ? 7'd0 : 7'd32);
        b.tag = 4'(tag);
        case ($urandom_range(0, 4))
            0: b.imm = 32'($urandom_range(0, 80)) - 32'd40;
            1: b.imm = 32'($urandom_range(0, 9000)) - 32'd4500;
            2: b.imm = $urandom;
            3: b.imm = $urandom & 32'hFFFFF000;
            default: b.imm = 32'($urandom_range(0, 2200000)) - 32'd1100000;
        endcase
        return b;
    endfunction

    task automatic drive(input bundle_t b);
        in_opcode = b.op; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2; in_funct3 = b.f3;
        in_funct7 = b.f7; in_funct12 = b.f12; in_imm = b.imm; in_tag = b.tag;
    endtask

    task automatic send(input bundle_t b);
        int n;
        drive(b);
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check_eq("send_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (q.size() != 0) check_eq("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard: samples handshakes mid-cycle, checks order, hold-under-stall and the counters.
    initial begin : monitor
        bit          prev_stall;
        logic [31:0] prev_inst;
        logic [3:0]  prev_tag;
        exp_t        e;
        int          sat_exp;
        prev_stall = 1'b0;
        prev_inst  = 32'd0;
        prev_tag   = 4'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                model_cnt  = 0;
                prev_stall = 1'b0;
            end else begin
                sat_exp = (model_cnt > 3) ? 3 : model_cnt;
                check_eq("err_count", {16'd0, err_count}, 32'(model_cnt));
                check_eq("err_count_sat", {30'd0, sat_err_count}, 32'(sat_exp));
                if (prev_stall) begin
                    check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
                    check_eq("hold_inst", out_inst, prev_inst);
                    check_eq("hold_tag", {28'd0, out_tag}, {28'd0, prev_tag});
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check_eq("spurious_out", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check_eq("out_inst", out_inst, e.inst);
                        check_eq("out_error", {31'd0, out_error}, {31'd0, e.err});
                        check_eq("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
                        check_eq("sat_out_inst", sat_out_inst, e.inst);
                        last = e;
                        if (e.err) model_cnt++;
                    end
                end
                if (in_valid && in_ready) begin
                    q.push_back(model(bundle_t'({in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
                                                 in_funct7, in_funct12, in_imm, in_tag})));
                end
                prev_stall = out_valid && !out_ready;
                prev_inst  = out_inst;
                prev_tag   = out_tag;
            end
        end
    end

    initial begin : stim
        int k, acc;
        bit fire;
        // Reset state
        #12;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_inst", out_inst, 32'd0);
        check_eq("rst_out_error", {31'd0, out_error}, 32'd0);
        check_eq("rst_out_tag", {28'd0, out_tag}, 32'd0);
        check_eq("rst_err_count", {16'd0, err_count}, 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADDI with latency check
        send(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 4'd3));
        check_eq("addi_lat1_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check_eq("addi_lat2_valid", {31'd0, out_valid}, 32'd1);
        drain();
        check_eq("addi_inst", last.inst, 32'h00500093);
        check_eq("addi_tag", {28'd0, last.tag}, 32'd3);

        send(mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 4'd4));
        drain();
        check_eq("lui_inst", last.inst, 32'h123452B7);
        send(mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFC, 4'd5));
        drain();
        check_eq("beq_inst", last.inst, 32'hFE208EE3);

        // Error bundles
        send(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 4'd6));
        drain();
        check_eq("err_addi_inst", last.inst, 32'd0);
        check_eq("err_addi_flag", {31'd0, last.err}, 32'd1);
        check_eq("err_cnt1", {16'd0, err_count}, 32'd1);
        send(mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3, 4'd7));
        drain();
        check_eq("err_cnt2", {16'd0, err_count}, 32'd2);
        send(mk(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0, 4'd8));
        drain();
        check_eq("err_cnt3", {16'd0, err_count}, 32'd3);

        // Backpressure: tags 0..3 back-to-back with the consumer stalled
        out_ready = 1'b0;
        k = 0; acc = 0;
        drive(mk(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 32'd0, 4'd0));
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            fire = in_ready;
            if (fire) acc++;
            if (c >= 2) check_eq("bp_hold_tag0", {28'd0, out_tag}, 32'd0);
            @(posedge clk); #1;
            if (fire) begin
                k++;
                drive(mk(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 32'(k), 4'(k)));
            end
        end
        @(negedge clk);
        check_eq("bp_accepted", 32'(acc), 32'd2);
        check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            fire = in_ready && in_valid;
            check_eq("bp_rel_valid", {31'd0, out_valid}, 32'd1);
            check_eq("bp_rel_tag", {28'd0, out_tag}, 32'(c));
            @(posedge clk); #1;
            if (fire) begin
                k++;
                if (k == 4) in_valid = 1'b0;
                else drive(mk(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 32'(k), 4'(k)));
            end
        end
        in_valid = 1'b0;
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(mk(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, 4'd9));
        send(mk(7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 32'd0, 4'd10));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_err_count", {16'd0, err_count}, 32'd0);
        check_eq("midrst_sat_count", {30'd0, sat_err_count}, 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 4'd3));
        check_eq("postrst_lat1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check_eq("postrst_lat2", {31'd0, out_valid}, 32'd1);
        check_eq("postrst_inst", out_inst, 32'h00500093);
        drain();

        // Saturation of the narrow counter
        for (int i = 0; i < 5; i++) send(mk(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 4'(i)));
        drain();
        check_eq("sat_stick", {30'd0, sat_err_count}, 32'd3);
        check_eq("wide_cnt5", {16'd0, err_count}, 32'd5);

        // Randomized bundles with random backpressure and input gaps
        rnd_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
            send(rand_bundle(i));
        end
        rnd_bp = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
